layer_bridge: RTL and testbench
===============================

LAYER_BRIDGE -- requirements
Module: layer_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the output element width (signed).
REQ-002 SHALL have parameter N_IN, default 128, meaning the upstream input count; it sets ACC_W = 2*DATA_W + $clog2(max(N_IN,2)).
REQ-003 SHALL have parameter N_OUT, default 64, meaning the number of accumulator results per vector.
REQ-004 SHALL have parameter SHIFT, default 8, meaning the requantisation right-shift amount, legal range 0..ACC_W-1.
REQ-005 SHALL have parameter RELU, default 1, meaning negative results are clamped to 0 when set to 1.
REQ-006 SHALL have port clk, input, 1 bit: the clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port in_data, input, ACC_W bits, signed: the accumulator result stream from the MAC engine.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; there is no backpressure.
REQ-010 SHALL have port vec_bus, output, N_OUT*DATA_W bits: the assembled vector, with element k at [k*DATA_W +: DATA_W].
REQ-011 SHALL have port vec_valid, output, 1 bit: vec_bus is complete and stable.
REQ-012 SHALL have port vec_ready, input, 1 bit: the downstream side accepts vec_bus.
REQ-013 SHALL have port next_start, output, 1 bit: a one-cycle pulse that starts the next layer.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag set when an input is dropped.
REQ-015 SHALL have port count, output, $clog2(N_OUT)+1 bits: the number of elements captured into the current vector.

Function
REQ-016 SHALL implement exactly two states:
- COLLECT: accumulating results.
- HOLD: presenting a full vector.
REQ-017 SHALL, in COLLECT on in_valid, write the processed element into slot count and increment count on the same clock edge.
REQ-018 SHALL, when the capture fills slot N_OUT-1, enter HOLD with vec_valid=1 in the next cycle, so vec_valid rises one cycle after the final in_valid.
REQ-019 SHALL keep vec_valid=1 and vec_bus constant in HOLD until a cycle where vec_valid && vec_ready.
REQ-020 SHALL, on that handshake edge, clear vec_valid, set count=0, enter COLLECT and drive next_start=1 for exactly the following cycle.
REQ-021 SHALL ignore vec_ready while in COLLECT.
REQ-022 SHALL, on in_valid in HOLD (including the handshake cycle itself), drop the data, leave vec_bus unchanged and set overrun=1.
REQ-023 SHALL clear overrun only on reset.
REQ-024 SHALL process each element with the following arithmetic:
- Compute in ACC_W+1 bits: sum = in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0), i.e. round half toward +infinity.
- Arithmetic-shift sum right by SHIFT.
- If RELU=1, force negative values to 0.
- Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 SHALL not clear slots between vectors; each slot is overwritten on its next capture.
REQ-026 SHALL contain no combinational path from any input to any output; all outputs are registered.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set the following and hold them while reset is held:
- state to COLLECT
- count to 0
- vec_valid to 0
- next_start to 0
- overrun to 0
- every vec_bus slot to 0
REQ-028 SHALL discard a partially collected vector when reset is asserted mid-collection; the first in_valid after reset writes slot 0.
REQ-029 SHALL ignore in_valid during any cycle with rst_n=0.

Verification
REQ-030 SHALL include a nominal directed test: N_OUT=4, SHIFT=8, RELU=0, in_data = 384, -384, 256, 127 on consecutive cycles -> vec_bus slots 2, -1, 1, 0; vec_valid rises the cycle after the 4th input; with vec_ready held 1, next_start pulses exactly once.
REQ-031 SHALL include a ReLU and saturation test: RELU=1, DATA_W=16, SHIFT=0, in_data = -5, 40000, -40000, 32767 -> slots 0, 32767, 0, 32767.
REQ-032 SHALL include a backpressure test: vec_ready held 0 for 10 cycles in HOLD -> vec_valid stays 1 and vec_bus is stable; vec_ready=1 -> next cycle vec_valid=0, next_start=1, count=0.
REQ-033 SHALL include an overrun test: in_valid pulsed in HOLD with in_data=999 -> overrun=1 stays set after the handshake; slots are unchanged; overrun clears only on reset.
REQ-034 SHALL include a mid-collection reset test: capture 2 elements, assert rst_n=0 for 1 cycle, then feed 4 elements -> vec_valid after exactly those 4 elements, with slot 0 equal to the first post-reset value.
REQ-035 SHALL include a gapped input test: the same 4 values as REQ-030 with 3 idle cycles between each -> identical vec_bus and vec_valid one cycle after the last input.

Source files
------------

// File: rtl/layer_bridge.sv
// rtl/layer_bridge.sv - requantises MAC accumulator results and assembles them into an output vector
module layer_bridge #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 128,
    parameter int N_OUT  = 64,
    parameter int SHIFT  = 8,
    parameter int RELU   = 1,
    localparam int ACC_W = 2 * DATA_W + $clog2((N_IN > 2) ? N_IN : 2),
    localparam int CNT_W = $clog2(N_OUT) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [ACC_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic [N_OUT*DATA_W-1:0]   vec_bus,
    output logic                      vec_valid,
    input  logic                      vec_ready,
    output logic                      next_start,
    output logic                      overrun,
    output logic [CNT_W-1:0]          count
);

    localparam int SUM_W = ACC_W + 1;
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // Half an output LSB, so the arithmetic shift rounds half toward +infinity
    localparam logic signed [SUM_W-1:0] RND =
        (SHIFT > 0) ? (SUM_W'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : SUM_W'(0);
    localparam logic signed [SUM_W-1:0] MAXV = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MINV = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] slot [N_OUT];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [DATA_W-1:0] elem;

    always_comb begin
        sum     = SUM_W'(in_data) + RND;
        shifted = sum >>> SHIFT;
        if (RELU == 1 && shifted[SUM_W-1]) begin
            shifted = '0;
        end
        if (shifted > MAXV) begin
            elem = MAXV[DATA_W-1:0];
        end else if (shifted < MINV) begin
            elem = MINV[DATA_W-1:0];
        end else begin
            elem = shifted[DATA_W-1:0];
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_flat
        assign vec_bus[k*DATA_W +: DATA_W] = slot[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            count      <= '0;
            vec_valid  <= 1'b0;
            next_start <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                slot[k] <= '0;
            end
        end else begin
            next_start <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        slot[count[IDX_W-1:0]] <= elem;
                        count                  <= count + CNT_W'(1);
                        if (count == CNT_W'(N_OUT - 1)) begin
                            state     <= HOLD;
                            vec_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Inputs arriving while the vector is held are lost, even on the handshake edge
                    if (in_valid) begin
                        overrun <= 1'b1;
                    end
                    if (vec_ready) begin
                        state      <= COLLECT;
                        vec_valid  <= 1'b0;
                        count      <= '0;
                        next_start <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_bridge.sv
// tb/tb_layer_bridge.sv - directed self-checking bench for layer_bridge
module tb_layer_bridge;

    localparam int DATA_W = 16;
    localparam int N_OUT  = 4;
    localparam int ACC_W  = 2 * DATA_W + 7;
    localparam int CNT_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic signed [ACC_W-1:0]  in_data;
    logic                     vld_a, vld_b, rdy_a, rdy_b;
    logic [N_OUT*DATA_W-1:0]  bus_a, bus_b;
    logic                     vv_a, vv_b, ns_a, ns_b, ov_a, ov_b;
    logic [CNT_W-1:0]         cnt_a, cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    layer_bridge #(.DATA_W(DATA_W), .N_IN(128), .N_OUT(N_OUT), .SHIFT(8), .RELU(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vld_a),
        .vec_bus(bus_a), .vec_valid(vv_a), .vec_ready(rdy_a),
        .next_start(ns_a), .overrun(ov_a), .count(cnt_a)
    );

    layer_bridge #(.DATA_W(DATA_W), .N_IN(128), .N_OUT(N_OUT), .SHIFT(0), .RELU(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vld_b),
        .vec_bus(bus_b), .vec_valid(vv_b), .vec_ready(rdy_b),
        .next_start(ns_b), .overrun(ov_b), .count(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] vec4(input int s0, input int s1, input int s2, input int s3);
        return {s3[15:0], s2[15:0], s1[15:0], s0[15:0]};
    endfunction

    task automatic send_a(input int v);
        in_data = ACC_W'(v);
        vld_a   = 1'b1;
        tick();
        vld_a   = 1'b0;
    endtask

    task automatic send_b(input int v);
        in_data = ACC_W'(v);
        vld_b   = 1'b1;
        tick();
        vld_b   = 1'b0;
    endtask

    initial begin
        int vals [4];
        int pulses;
        vals = '{384, -384, 256, 127};

        rst_n = 1'b0; in_data = '0;
        vld_a = 1'b0; vld_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        tick();
        tick();
        check("rst_count",   64'(cnt_a), 0);
        check("rst_valid",   64'(vv_a), 0);
        check("rst_next",    64'(ns_a), 0);
        check("rst_overrun", 64'(ov_a), 0);
        check("rst_bus_a",   bus_a, 0);
        check("rst_bus_b",   bus_b, 0);

        // nominal vector, vec_ready held high throughout
        rst_n = 1'b1;
        rdy_a = 1'b1;
        send_a(384);
        check("nom_count1", 64'(cnt_a), 1);
        check("nom_valid1", 64'(vv_a), 0);
        send_a(-384);
        send_a(256);
        send_a(127);
        check("nom_valid", 64'(vv_a), 1);
        check("nom_count", 64'(cnt_a), 4);
        check("nom_bus",   bus_a, vec4(2, -1, 1, 0));
        check("nom_next0", 64'(ns_a), 0);
        tick();
        check("nom_hs_valid", 64'(vv_a), 0);
        check("nom_hs_next",  64'(ns_a), 1);
        check("nom_hs_count", 64'(cnt_a), 0);
        pulses = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ns_a) pulses++;
        end
        check("nom_pulses", 64'(pulses), 1);

        // backpressure with an overrun pulse while held
        rdy_a = 1'b0;
        send_a(1000);
        send_a(-1000);
        send_a(512);
        send_a(-129);
        check("bp_valid", 64'(vv_a), 1);
        check("bp_bus",   bus_a, vec4(4, -4, 2, -1));
        for (int i = 0; i < 10; i++) begin
            vld_a   = (i == 3);
            in_data = ACC_W'(999);
            tick();
            vld_a   = 1'b0;
            check("bp_hold_valid", 64'(vv_a), 1);
            check("bp_hold_bus",   bus_a, vec4(4, -4, 2, -1));
            check("bp_overrun",    64'(ov_a), 64'(i >= 3));
        end
        rdy_a   = 1'b1;
        vld_a   = 1'b1;
        in_data = ACC_W'(999);
        tick();
        vld_a = 1'b0;
        rdy_a = 1'b0;
        check("bp_rel_valid",   64'(vv_a), 0);
        check("bp_rel_next",    64'(ns_a), 1);
        check("bp_rel_count",   64'(cnt_a), 0);
        check("bp_rel_overrun", 64'(ov_a), 1);
        check("bp_rel_bus",     bus_a, vec4(4, -4, 2, -1));
        tick();
        check("bp_next_once",   64'(ns_a), 0);
        check("bp_ovr_sticky",  64'(ov_a), 1);
        check("bp_drop_count",  64'(cnt_a), 0);

        // reset in the middle of a vector
        send_a(5000);
        send_a(6000);
        check("mr_count2", 64'(cnt_a), 2);
        rst_n   = 1'b0;
        vld_a   = 1'b1;
        in_data = ACC_W'(7000);
        tick();
        rst_n = 1'b1;
        vld_a = 1'b0;
        check("mr_count",   64'(cnt_a), 0);
        check("mr_overrun", 64'(ov_a), 0);
        check("mr_bus",     bus_a, 0);
        send_a(256);
        send_a(512);
        send_a(768);
        check("mr_count3", 64'(cnt_a), 3);
        check("mr_valid3", 64'(vv_a), 0);
        send_a(-256);
        check("mr_valid", 64'(vv_a), 1);
        check("mr_bus4",  bus_a, vec4(1, 2, 3, -1));

        // gapped input stream
        rdy_a = 1'b1;
        tick();
        check("gap_hs_next", 64'(ns_a), 1);
        rdy_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_a(vals[i]);
            check("gap_count", 64'(cnt_a), 64'(i + 1));
            check("gap_valid", 64'(vv_a), 64'(i == 3));
            if (i < 3) begin
                repeat (3) tick();
            end
        end
        check("gap_bus", bus_a, vec4(2, -1, 1, 0));

        // ReLU clamp and saturation on the unshifted instance
        send_b(-5);
        send_b(40000);
        send_b(-40000);
        send_b(32767);
        check("relu_valid", 64'(vv_b), 1);
        check("relu_count", 64'(cnt_b), 4);
        check("relu_bus",   bus_b, vec4(0, 32767, 0, 32767));
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;
        check("relu_next",  64'(ns_b), 1);
        check("relu_clear", 64'(vv_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
